vehicle_detector: RTL and testbench

- Producer end of the vehicle-detect interface consumed by the Traffic controller core.
- Takes raw, noisy inductive-loop sensor levels for the NS and EW approaches.
- Synchronises and debounces them, counts queued vehicles per approach, and retires them as they leave the loop on that approach's green.
- Drives NS_VEHICLE_DETECT / EW_VEHICLE_DETECT with a minimum hold time, and flags illegal green feedback.

---
 rtl/vehicle_detector.sv | 135 +++++++++++++
 tb/tb_vehicle_detector.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vehicle_detector.sv
// Loop-sensor front end: synchronises and debounces the NS/EW loops, keeps per-approach
// vehicle queues and drives held vehicle-detect demands plus a sticky green-conflict flag.
module vd_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int QUEUE_MAX       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loop_i,
    input  logic       green_i,
    output logic       det_o,
    output logic [3:0] queue_o
);
    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] QMAX      = 4'(QUEUE_MAX);
    localparam logic [4:0] HOLD_LOAD = 5'(HOLD_CYCLES - 1);

    logic       s1_q, s2_q;
    logic       deb_q, deb_d, deb_prev_q;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] queue_q, queue_d;
    logic [4:0] hold_q, hold_d;
    logic       det_q, det_d;
    logic       arrive, depart, request;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == DEB_LAST) deb_d = s2_q;
            else                   cnt_d = cnt_q + 4'd1;
        end

        // Edges are taken from the registered debounced level, one cycle behind deb.
        arrive  = deb_q & ~deb_prev_q;
        depart  = ~deb_q & deb_prev_q & green_i;
        queue_d = queue_q;
        if (arrive && queue_q != QMAX)       queue_d = queue_q + 4'd1;
        else if (depart && queue_q != 4'd0)  queue_d = queue_q - 4'd1;

        request = (queue_d != 4'd0) | deb_q;
        det_d   = det_q;
        hold_d  = hold_q;
        if (!det_q) begin
            if (request) begin
                det_d  = 1'b1;
                hold_d = HOLD_LOAD;
            end
        end else if (hold_q != 5'd0) begin
            hold_d = hold_q - 5'd1;
        end else begin
            det_d = request;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
            queue_q    <= '0;
            hold_q     <= '0;
            det_q      <= 1'b0;
        end else begin
            s1_q       <= loop_i;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            queue_q    <= queue_d;
            hold_q     <= hold_d;
            det_q      <= det_d;
        end
    end

    assign det_o   = det_q;
    assign queue_o = queue_q;
endmodule

module vehicle_detector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int QUEUE_MAX       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       NS_LOOP,
    input  logic       EW_LOOP,
    input  logic       NS_GREEN,
    input  logic       EW_GREEN,
    output logic       NS_VEHICLE_DETECT,
    output logic       EW_VEHICLE_DETECT,
    output logic [3:0] NS_QUEUE,
    output logic [3:0] EW_QUEUE,
    output logic       GREEN_CONFLICT
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]      loop, green, det;
    logic [NUM_LANES-1:0][3:0] queue;
    logic                      conflict_q;

    assign loop  = {EW_LOOP, NS_LOOP};
    assign green = {EW_GREEN, NS_GREEN};

    // Lane 0 is NS, lane 1 is EW.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        vd_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .QUEUE_MAX      (QUEUE_MAX)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .loop_i (loop[l]),
            .green_i(green[l]),
            .det_o  (det[l]),
            .queue_o(queue[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) conflict_q <= 1'b0;
        else     conflict_q <= conflict_q | (NS_GREEN & EW_GREEN);
    end

    assign NS_VEHICLE_DETECT = det[0];
    assign EW_VEHICLE_DETECT = det[1];
    assign NS_QUEUE          = queue[0];
    assign EW_QUEUE          = queue[1];
    assign GREEN_CONFLICT    = conflict_q;
endmodule

// File: tb/tb_vehicle_detector.sv
// Bench for vehicle_detector: vector table, directed corner sequences and a randomized
// run, all compared every cycle against a sliding-window / timestamp reference model.
module tb_vehicle_detector;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int QMAX = 15;

    logic       clk, rst;
    logic       NS_LOOP, EW_LOOP, NS_GREEN, EW_GREEN;
    logic       NS_VEHICLE_DETECT, EW_VEHICLE_DETECT, GREEN_CONFLICT;
    logic [3:0] NS_QUEUE, EW_QUEUE;

    vehicle_detector #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .QUEUE_MAX(QMAX)) dut (
        .clk              (clk),
        .rst              (rst),
        .NS_LOOP          (NS_LOOP),
        .EW_LOOP          (EW_LOOP),
        .NS_GREEN         (NS_GREEN),
        .EW_GREEN         (EW_GREEN),
        .NS_VEHICLE_DETECT(NS_VEHICLE_DETECT),
        .EW_VEHICLE_DETECT(EW_VEHICLE_DETECT),
        .NS_QUEUE         (NS_QUEUE),
        .EW_QUEUE         (EW_QUEUE),
        .GREEN_CONFLICT   (GREEN_CONFLICT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: raw-sample history, a window test for debounce, clamped
    // integer queues and a rise timestamp for the detect hold.
    logic [31:0] smp_h[2], used_h[2];
    int          smp_n[2], used_n[2];
    bit          m_deb[2], m_prev[2], m_det[2];
    int          m_q[2], m_rise[2];
    int          m_t = 0;
    bit          m_conf;

    initial begin
        for (int l = 0; l < 2; l++) begin
            smp_h[l] = '0; used_h[l] = '0; smp_n[l] = 0; used_n[l] = 0;
            m_deb[l] = 0; m_prev[l] = 0; m_det[l] = 0; m_q[l] = 0; m_rise[l] = 0;
        end
        m_conf = 0;
    end

    always @(posedge clk) begin
        bit lp, g, s2u, dly, flip, req;
        m_t++;
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                smp_h[l] = '0; used_h[l] = '0; smp_n[l] = 0; used_n[l] = 0;
                m_deb[l] = 0; m_prev[l] = 0; m_det[l] = 0; m_q[l] = 0;
            end else begin
                lp  = (l == 0) ? NS_LOOP  : EW_LOOP;
                g   = (l == 0) ? NS_GREEN : EW_GREEN;
                // loop value sampled two edges ago reaches the debouncer now
                s2u = (smp_n[l] >= 2) ? smp_h[l][1] : 1'b0;
                used_h[l] = {used_h[l][30:0], s2u};
                used_n[l]++;
                if (m_deb[l] && !m_prev[l])      m_q[l] = (m_q[l] + 1 > QMAX) ? QMAX : m_q[l] + 1;
                else if (!m_deb[l] && m_prev[l] && g) m_q[l] = (m_q[l] - 1 < 0) ? 0 : m_q[l] - 1;
                dly  = m_deb[l];
                flip = (used_n[l] >= DEB);
                for (int i = 0; i < DEB; i++)
                    if (used_h[l][i] == m_deb[l]) flip = 0;
                if (flip) m_deb[l] = !m_deb[l];
                m_prev[l] = dly;
                req = (m_q[l] != 0) || dly;
                if (!m_det[l]) begin
                    if (req) begin m_det[l] = 1; m_rise[l] = m_t; end
                end else if (m_t - m_rise[l] >= HOLD) begin
                    m_det[l] = req;
                end
                smp_h[l] = {smp_h[l][30:0], lp};
                smp_n[l]++;
            end
        end
        if (rst) m_conf = 0;
        else if (NS_GREEN && EW_GREEN) m_conf = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk("ns_detect_model", NS_VEHICLE_DETECT, m_det[0]);
        chk("ew_detect_model", EW_VEHICLE_DETECT, m_det[1]);
        chk("ns_queue_model",  NS_QUEUE, m_q[0]);
        chk("ew_queue_model",  EW_QUEUE, m_q[1]);
        chk("conflict_model",  GREEN_CONFLICT, m_conf);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1; NS_LOOP = 0; EW_LOOP = 0; NS_GREEN = 0; EW_GREEN = 0;
        tick();
        rst = 0;
    endtask

    typedef struct {
        bit rst, nl, el, ng, eg;
        bit edn, ede;
        int enq, eeq;
        bit ec;
    } vec_t;

    vec_t tbl[12];
    int   hi_cnt;
    int   run[2];
    int   gsel;

    initial begin
        rst = 1; NS_LOOP = 1; EW_LOOP = 1; NS_GREEN = 0; EW_GREEN = 0;
        // reset with loops high, first arrival six edges after release, then conflict
        for (int r = 0; r < 3; r++)  tbl[r] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        for (int r = 3; r < 9; r++)  tbl[r] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0};
        tbl[10] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        tbl[11] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        for (int r = 0; r < 12; r++) begin
            rst = tbl[r].rst; NS_LOOP = tbl[r].nl; EW_LOOP = tbl[r].el;
            NS_GREEN = tbl[r].ng; EW_GREEN = tbl[r].eg;
            tick();
            chk($sformatf("tbl%0d_ns_det", r), NS_VEHICLE_DETECT, tbl[r].edn);
            chk($sformatf("tbl%0d_ew_det", r), EW_VEHICLE_DETECT, tbl[r].ede);
            chk($sformatf("tbl%0d_ns_q", r), NS_QUEUE, tbl[r].enq);
            chk($sformatf("tbl%0d_ew_q", r), EW_QUEUE, tbl[r].eeq);
            chk($sformatf("tbl%0d_conf", r), GREEN_CONFLICT, tbl[r].ec);
        end
        ticks(5);
        chk("conflict_sticky", GREEN_CONFLICT, 1);

        // glitch rejection: 3-cycle pulses never pass the debouncer
        do_reset();
        chk("conflict_cleared", GREEN_CONFLICT, 0);
        for (int p = 0; p < 5; p++) begin
            NS_LOOP = 1;
            for (int i = 0; i < 3; i++) begin
                tick(); chk("glitch_q", NS_QUEUE, 0); chk("glitch_det", NS_VEHICLE_DETECT, 0);
            end
            NS_LOOP = 0;
            for (int i = 0; i < 3; i++) begin
                tick(); chk("glitch_q", NS_QUEUE, 0); chk("glitch_det", NS_VEHICLE_DETECT, 0);
            end
        end
        ticks(8);
        chk("glitch_q_end", NS_QUEUE, 0);

        // arrival on red stays queued, next vehicle on green serves the queue
        do_reset();
        EW_LOOP = 1; ticks(10); EW_LOOP = 0; ticks(20);
        chk("ew_red_q", EW_QUEUE, 1);
        chk("ew_red_det", EW_VEHICLE_DETECT, 1);
        EW_GREEN = 1;
        EW_LOOP = 1; ticks(10); EW_LOOP = 0; ticks(25);
        chk("ew_green_q", EW_QUEUE, 1);
        chk("ew_green_det", EW_VEHICLE_DETECT, 1);
        EW_GREEN = 0;

        // minimum hold: 5-cycle vehicle on green gives an 8-cycle detect
        do_reset();
        EW_GREEN = 1; hi_cnt = 0;
        EW_LOOP = 1;
        for (int i = 0; i < 5; i++) begin tick(); hi_cnt += int'(EW_VEHICLE_DETECT); end
        EW_LOOP = 0;
        for (int i = 0; i < 30; i++) begin tick(); hi_cnt += int'(EW_VEHICLE_DETECT); end
        chk("min_hold_cycles", hi_cnt, HOLD);
        chk("min_hold_q", EW_QUEUE, 0);
        EW_GREEN = 0;

        // saturation at 15, then a saturated arrival departing on green drops to 14
        do_reset();
        for (int a = 1; a <= 17; a++) begin
            NS_LOOP = 1; ticks(6); NS_LOOP = 0; ticks(6);
            chk($sformatf("sat_q_%0d", a), NS_QUEUE, (a < QMAX) ? a : QMAX);
        end
        NS_LOOP = 1; ticks(8);
        chk("sat_hold_15", NS_QUEUE, 15);
        NS_GREEN = 1; NS_LOOP = 0; ticks(8);
        chk("sat_depart_14", NS_QUEUE, 14);
        NS_LOOP = 1; ticks(8); NS_LOOP = 0; ticks(8);
        chk("green_pulse_net0", NS_QUEUE, 14);
        NS_GREEN = 0;

        // randomized traffic with occasional conflicts and mid-run resets
        do_reset();
        run[0] = 0; run[1] = 0; gsel = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run[0] == 0) begin NS_LOOP = ~NS_LOOP; run[0] = $urandom_range(1, 14); end
            if (run[1] == 0) begin EW_LOOP = ~EW_LOOP; run[1] = $urandom_range(1, 14); end
            run[0]--; run[1]--;
            if ($urandom_range(0, 19) == 0) gsel = $urandom_range(0, 2);
            NS_GREEN = (gsel == 1);
            EW_GREEN = (gsel == 2);
            if ($urandom_range(0, 299) == 0) begin NS_GREEN = 1; EW_GREEN = 1; end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
